aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES-128 decryption engine: the receive-side counterpart of the unrolled `AES` encryptor. It takes a 128-bit ciphertext and the original cipher key and returns the plaintext. It computes one round per clock and runs the key schedule forward, then backward, on the fly, so no round-key storage is needed. It sits behind the `AES` block in the HW5 datapath, and `AES` → `aes_inv_cipher` must form an identity loop.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset (sampled on rising `clk`, active when 0).
- `start` input 1: request; sampled only in IDLE or DONE.
- `C` input 128: ciphertext; sampled on the edge `start` is accepted.
- `K` input 128: cipher key (round key 0); sampled with `C`.
- `P` output 128: plaintext register; 0 after reset; holds the last result until the next accepted `start`.
- `valid` output 1: high while `P` holds a completed result; 0 after reset.
- `busy` output 1: high in KEYEXP/ARK/ROUND; 0 after reset.

## Operation
- Byte order follows FIPS-197: bits [127:120] are byte 0. The state is column-major; word w0 = [127:96].
- States and transitions:
  - IDLE →(start) KEYEXP.
  - KEYEXP (10 cycles) → ARK (1 cycle) → ROUND (10 cycles) → DONE.
  - DONE →(start) KEYEXP.
- Start accept (edge E0):
  - Load `C` into the state register and `K` into the key register.
  - Clear `valid`, set `busy`, set round counter to 1.
- KEYEXP, edges E1..E10: key ← forward step(key, Rcon[i]), i = 1..10. After E10 the key register holds rk10.
- ARK, edge E11: state ← state ^ rk10; key ← backward step(rk10, Rcon[10]) = rk9.
- ROUND, edges E12..E21, r = 9 down to 0:
  - r ≥ 1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r).
  - r = 0: state ← InvSubBytes(InvShiftRows(state)) ^ rk0, with no InvMixColumns.
  - key ← backward step(rk_r, Rcon[r]) for r ≥ 1; the key register holds at r = 0.
- Edge E21: `P` ← final state, `valid` ← 1, `busy` ← 0, go to DONE.
- Forward step: w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
- Backward step, from rk_i to rk_{i-1}:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[i].
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- GF(2^8) multiplies use x^8+x^4+x^3+x+1. InvMixColumns coefficients are 0e,0b,0d,09.
- `start` while busy is ignored, with no queuing. `C`/`K` changes mid-operation have no effect.
- `start` in DONE restarts immediately; `valid` drops on that same edge.
- `rst`=0 in any state → IDLE on that edge. `P`, `valid`, `busy` and all internal registers clear, including mid-operation.
- `rst`=0 together with `start`=1: reset wins.

## Timing
- Latency: `start` accepted at E0 → `valid`=1 and `P` correct after E21 (21 cycles). Throughput is one block per 21 cycles; back-to-back starts from DONE give 21-cycle spacing.
- `busy` is high for exactly 21 cycles, from after E0 through E21 exclusive.
- All outputs are registered; no combinational path from inputs to outputs.
- The critical path is one inverse round (shift, S-box, XOR, InvMixColumns) in parallel with one key step (S-box, XOR chain).

## Structure
- Package `aes_pkg`:
  - 256-entry `SBOX` and `INV_SBOX` constant arrays.
  - `RCON[1:10]`.
  - Functions `xtime`, `gmul`, `inv_shift_rows`, `inv_mix_columns`, `sub_word`.
  - State enum `{IDLE, KEYEXP, ARK, ROUND, DONE}`.
- Sub-module `aes_key_step`:
  - Inputs: 128-bit key, 8-bit rcon, direction bit (0 = forward, 1 = backward).
  - Output: 128-bit next round key.
  - Combinational, one instance.
- The top holds the FSM, 4-bit round counter, state/key/P registers, and the round datapath.

## Test plan
- FIPS-197 C.1: K=000102030405060708090a0b0c0d0e0f, C=69c4e0d86a7b0430d8cdb78070b4c55a → P=00112233445566778899aabbccddeeff, `valid` rises exactly 21 cycles after the start edge.
- FIPS-197 App. B: K=2b7e151628aed2a6abf7158809cf4f3c, C=3925841d02dc09fbdc118597196a0b32 → P=3243f6a8885a308d313198a2e0370734. Also check the key register equals d014f9a8c9ee2589e13f0cc8b6630ca6 after E10.
- Pulse `start` with new C/K at cycle 5 of a run → ignored; the original result is produced at cycle 21 and `busy` is unaffected.
- Drive `rst`=0 at cycle 12 of a run → `P`=0, `valid`=0, `busy`=0 next cycle. A fresh start then yields the correct C.1 result.
- Loopback: 1000 random P/K through the `AES` encryptor, then this block → output equals the original P for every vector.
- Back-to-back restart from DONE with C.1 then App. B vectors → `valid` low for exactly 21 cycles between results, and both plaintexts are correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers for the iterative inverse cipher.
// Bytes are FIPS-197 ordered: bits [127:120] are byte 0, and the state is stored column-major.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, ARK, ROUND, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant coefficients at every call site, so synthesis reduces this to a few XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step in either direction: forward rk_i -> rk_{i+1}, backward rk_i -> rk_{i-1}.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, t;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] b0, b1, b2, b3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // Backward w3' equals w3^w2, so both directions share a single SubWord.
  assign b3     = w3 ^ w2;
  assign sub_in = dir ? b3 : w3;
  assign t      = sub_word({sub_in[23:0], sub_in[31:24]}) ^ {rcon, 24'h000000};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;
  assign b0 = w0 ^ t;

  assign next_key = dir ? {b0, b1, b2, b3} : {f0, f1, f2, f3};

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: 10 forward key steps to reach rk10, then one inverse round per clock
// while the key schedule walks back down, so no round keys are stored.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] C,
  input  logic [127:0] K,
  output logic [127:0] P,
  output logic         valid,
  output logic         busy
);

  // Handshake: start is a request accepted only on a rising edge in IDLE or DONE (never while busy,
  // and not queued); valid stays high while P holds a finished result and drops when the next start is taken.
  state_t       fsm;
  logic [3:0]   cnt;
  logic [127:0] blk;
  logic [127:0] rkey;
  logic [127:0] next_key;
  logic [127:0] ark_out;
  logic [127:0] round_out;
  logic [7:0]   rcon;
  logic         dir;

  always_comb begin
    rcon = 8'h00;
    if (cnt >= 4'd1 && cnt <= 4'd10) rcon = RCON[cnt];
    dir = (fsm != KEYEXP);
  end

  aes_key_step u_key_step (
    .key      (rkey),
    .rcon     (rcon),
    .dir      (dir),
    .next_key (next_key)
  );

  // The last round (cnt == 0) skips InvMixColumns.
  always_comb begin
    ark_out   = inv_sub_bytes(inv_shift_rows(blk)) ^ rkey;
    round_out = (cnt == 4'd0) ? ark_out : inv_mix_columns(ark_out);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm   <= IDLE;
      cnt   <= 4'd0;
      blk   <= '0;
      rkey  <= '0;
      P     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (start) begin
            blk   <= C;
            rkey  <= K;
            cnt   <= 4'd1;
            valid <= 1'b0;
            busy  <= 1'b1;
            fsm   <= KEYEXP;
          end
        end
        KEYEXP: begin
          rkey <= next_key;
          if (cnt == 4'd10) fsm <= ARK;
          else cnt <= cnt + 4'd1;
        end
        ARK: begin
          blk  <= blk ^ rkey;
          rkey <= next_key;
          cnt  <= 4'd9;
          fsm  <= ROUND;
        end
        ROUND: begin
          blk <= round_out;
          if (cnt == 4'd0) begin
            P     <= round_out;
            valid <= 1'b1;
            busy  <= 1'b0;
            fsm   <= DONE;
          end else begin
            rkey <= next_key;
            cnt  <= cnt - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
